fifo_sync_param: RTL and testbench

FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_mem.sv | 37 +++
 rtl/fifo_sync_param.sv | 137 +++++++++++++
 tb/tb_fifo_sync_param.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared opcode encodings and constant helpers for the synchronous FIFO.
package fifo_pkg;

  localparam logic [1:0] OP_NOP        = 2'b00;
  localparam logic [1:0] OP_READ       = 2'b01;
  localparam logic [1:0] OP_WRITE      = 2'b10;
  localparam logic [1:0] OP_READ_WRITE = 2'b11;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x DATA_WIDTH array, one write port, one registered read port.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  // Read samples the pre-edge array, so a same-slot write never bypasses.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock parameterised FIFO with opcode-driven access and registered status.
// Define FIFO_ERR_FLAGS_EN to enable sticky overflow/underflow flags.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 16,
  parameter  int AF_THRESH  = DEPTH - 2,
  parameter  int AE_THRESH  = 2,
  localparam int ADDR_WIDTH = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH+1:0] vector_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  empty_flag,
  output logic                  full_flag,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [1:0] op;
  logic       rd_req, wr_req, is_empty, is_full, rd_ok, wr_ok;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  data_valid_q, data_valid_d;
  logic                  empty_q, empty_d, full_q, full_d;
  logic                  ae_q, ae_d, af_q, af_d;

  assign op       = vector_in[DATA_WIDTH+1:DATA_WIDTH];
  assign rd_req   = (op == OP_READ)  || (op == OP_READ_WRITE);
  assign wr_req   = (op == OP_WRITE) || (op == OP_READ_WRITE);
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DEPTH_C);

  // A simultaneous read frees the slot, so a full FIFO still accepts READ_WRITE.
  assign rd_ok = rd_req && !is_empty;
  assign wr_ok = wr_req && (!is_full || rd_ok);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    data_valid_d = rd_ok;
    if (wr_ok) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_C);
    ae_d    = (count_d <= AE_C);
    af_d    = (count_d >= AF_C);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_valid_q <= 1'b0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      ae_q         <= 1'b1;
      af_q         <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      data_valid_q <= data_valid_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      ae_q         <= ae_d;
      af_q         <= af_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr_q),
    .wr_data (vector_in[DATA_WIDTH-1:0]),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr_q),
    .rd_data (data_out)
  );

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d, underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (wr_req & ~wr_ok);
    underflow_d = underflow_q | (rd_req & is_empty);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign data_valid   = data_valid_q;
  assign empty_flag   = empty_q;
  assign full_flag    = full_q;
  assign almost_empty = ae_q;
  assign almost_full  = af_q;
  assign count        = count_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param with DEPTH=4, AF_THRESH=3, AE_THRESH=1.
module tb_fifo_sync_param;
  import fifo_pkg::*;

`ifdef FIFO_ERR_FLAGS_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] vector_in = '0;
  logic [7:0] data_out;
  logic       data_valid, empty_flag, full_flag, almost_empty, almost_full;
  logic [2:0] count;
  logic       overflow, underflow;
  logic [6:0] st;

  int errors = 0;
  int checks = 0;

  fifo_sync_param #(
    .DATA_WIDTH (8),
    .DEPTH      (4),
    .AF_THRESH  (3),
    .AE_THRESH  (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .vector_in    (vector_in),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .empty_flag   (empty_flag),
    .full_flag    (full_flag),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  // Status packed as {count, empty, full, almost_empty, almost_full}
  assign st = {count, empty_flag, full_flag, almost_empty, almost_full};

  task automatic do_op(input logic [1:0] op, input logic [7:0] data);
    @(negedge clk);
    vector_in = {op, data};
    @(posedge clk);
    #1;
    vector_in = {OP_NOP, 8'h00};
  endtask

  task automatic apply_reset();
    @(negedge clk);
    vector_in = {OP_NOP, 8'h00};
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    vector_in = {OP_NOP, 8'h00};
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (st !== {3'd0, 4'b1010}) begin
      errors++; $display("FAIL reset_status: got %b expected %b", st, {3'd0, 4'b1010});
    end
    checks++;
    if ({data_out, data_valid, overflow, underflow} !== 11'h0) begin
      errors++; $display("FAIL reset_outputs: got dout=%h dv=%b ovf=%b udf=%b expected all 0",
                         data_out, data_valid, overflow, underflow);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_async_reset_mid_write();
    do_op(OP_WRITE, 8'h77);
    do_op(OP_WRITE, 8'h66);
    do_op(OP_READ, 8'h00);
    checks++;
    if (data_out !== 8'h77 || count !== 3'd1) begin
      errors++; $display("FAIL pre_reset_read: got dout=%h count=%0d expected 77 1", data_out, count);
    end
    @(negedge clk);
    vector_in = {OP_WRITE, 8'h99};
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (st !== {3'd0, 4'b1010} || data_out !== 8'h00 || data_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset: got st=%b dout=%h dv=%b expected 0001010 00 0",
                         st, data_out, data_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (count !== 3'd0 || empty_flag !== 1'b1) begin
      errors++; $display("FAIL reset_hold: got count=%0d empty=%b expected 0 1", count, empty_flag);
    end
    @(negedge clk);
    vector_in = {OP_NOP, 8'h00};
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (st !== {3'd0, 4'b1010} || data_out !== 8'h00) begin
      errors++; $display("FAIL post_reset: got st=%b dout=%h expected 0001010 00", st, data_out);
    end
  endtask

  task automatic test_fill_overflow();
    logic [7:0] vals [4];
    logic [6:0] exp_st [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_st = '{{3'd1, 4'b0010}, {3'd2, 4'b0000}, {3'd3, 4'b0001}, {3'd4, 4'b0101}};
    for (int i = 0; i < 4; i++) begin
      do_op(OP_WRITE, vals[i]);
      checks++;
      if (st !== exp_st[i] || data_valid !== 1'b0) begin
        errors++; $display("FAIL fill_%0d: got st=%b dv=%b expected %b 0", i, st, data_valid, exp_st[i]);
      end
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_early: got %b expected 0", overflow);
    end
    do_op(OP_WRITE, 8'h55);
    checks++;
    if (st !== {3'd4, 4'b0101} || overflow !== ERR_EN) begin
      errors++; $display("FAIL overflow: got st=%b ovf=%b expected 1000101 %b", st, overflow, ERR_EN);
    end
  endtask

  task automatic test_drain_underflow();
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      do_op(OP_READ, 8'h00);
      checks++;
      if (data_out !== vals[i] || data_valid !== 1'b1 || count !== 3'(3 - i)) begin
        errors++; $display("FAIL drain_%0d: got dout=%h dv=%b count=%0d expected %h 1 %0d",
                           i, data_out, data_valid, count, vals[i], 3 - i);
      end
    end
    do_op(OP_NOP, 8'h00);
    checks++;
    if (data_valid !== 1'b0 || data_out !== 8'h44 || st !== {3'd0, 4'b1010}) begin
      errors++; $display("FAIL nop_stable: got dv=%b dout=%h st=%b expected 0 44 0001010",
                         data_valid, data_out, st);
    end
    checks++;
    if (underflow !== 1'b0) begin
      errors++; $display("FAIL udf_early: got %b expected 0", underflow);
    end
    do_op(OP_READ, 8'h00);
    checks++;
    if (data_valid !== 1'b0 || data_out !== 8'h44 || underflow !== ERR_EN ||
        st !== {3'd0, 4'b1010} || overflow !== ERR_EN) begin
      errors++; $display("FAIL underflow: got dv=%b dout=%h udf=%b ovf=%b st=%b expected 0 44 %b %b 0001010",
                         data_valid, data_out, underflow, overflow, st, ERR_EN, ERR_EN);
    end
  endtask

  task automatic test_rw_full();
    logic [7:0] after [4];
    after = '{8'h02, 8'h03, 8'h04, 8'hAA};
    apply_reset();
    for (int i = 1; i <= 4; i++) do_op(OP_WRITE, 8'(i));
    do_op(OP_READ_WRITE, 8'hAA);
    checks++;
    if (data_out !== 8'h01 || data_valid !== 1'b1 || st !== {3'd4, 4'b0101} || overflow !== 1'b0) begin
      errors++; $display("FAIL rw_full: got dout=%h dv=%b st=%b ovf=%b expected 01 1 1000101 0",
                         data_out, data_valid, st, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      do_op(OP_READ, 8'h00);
      checks++;
      if (data_out !== after[i] || data_valid !== 1'b1) begin
        errors++; $display("FAIL rw_full_drain_%0d: got dout=%h dv=%b expected %h 1",
                           i, data_out, data_valid, after[i]);
      end
    end
  endtask

  task automatic test_rw_empty();
    checks++;
    if (st !== {3'd0, 4'b1010} || underflow !== 1'b0) begin
      errors++; $display("FAIL rw_empty_pre: got st=%b udf=%b expected 0001010 0", st, underflow);
    end
    do_op(OP_READ_WRITE, 8'h5A);
    checks++;
    if (st !== {3'd1, 4'b0010} || data_valid !== 1'b0 || data_out !== 8'hAA || underflow !== ERR_EN) begin
      errors++; $display("FAIL rw_empty: got st=%b dv=%b dout=%h udf=%b expected 0010010 0 aa %b",
                         st, data_valid, data_out, underflow, ERR_EN);
    end
    do_op(OP_READ, 8'h00);
    checks++;
    if (data_out !== 8'h5A || data_valid !== 1'b1 || count !== 3'd0) begin
      errors++; $display("FAIL rw_empty_read: got dout=%h dv=%b count=%0d expected 5a 1 0",
                         data_out, data_valid, count);
    end
  endtask

  task automatic test_rw_mid();
    do_op(OP_WRITE, 8'hB1);
    do_op(OP_WRITE, 8'hB2);
    do_op(OP_READ_WRITE, 8'hB3);
    checks++;
    if (data_out !== 8'hB1 || data_valid !== 1'b1 || st !== {3'd2, 4'b0000}) begin
      errors++; $display("FAIL rw_mid: got dout=%h dv=%b st=%b expected b1 1 0100000",
                         data_out, data_valid, st);
    end
    do_op(OP_READ, 8'h00);
    do_op(OP_READ, 8'h00);
    checks++;
    if (data_out !== 8'hB3 || count !== 3'd0) begin
      errors++; $display("FAIL rw_mid_tail: got dout=%h count=%0d expected b3 0", data_out, count);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] v;
    for (int i = 0; i < 10; i++) begin
      v = 8'hC0 + 8'(i);
      do_op(OP_WRITE, v);
      checks++;
      if (st !== {3'd1, 4'b0010}) begin
        errors++; $display("FAIL wrap_wr_%0d: got st=%b expected 0010010", i, st);
      end
      do_op(OP_READ, 8'h00);
      checks++;
      if (data_out !== v || data_valid !== 1'b1 || st !== {3'd0, 4'b1010}) begin
        errors++; $display("FAIL wrap_rd_%0d: got dout=%h dv=%b st=%b expected %h 1 0001010",
                           i, data_out, data_valid, st, v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_async_reset_mid_write();
    test_fill_overflow();
    test_drain_underflow();
    test_rw_full();
    test_rw_empty();
    test_rw_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
